// File: rtl/plab5_mcore_mem_net_rr_pkg.sv
// Shared types and message-width helpers for the round-robin multi-port memory net.
// Widths follow the vc mem message layout: {type(3), opaque, addr, len, data} for requests.
package plab5_mcore_mem_net_rr_pkg;

  localparam int TagSrcNbits = 8;

  typedef logic [TagSrcNbits-1:0] tagSrc_t;

  typedef struct packed {
    tagSrc_t src;
    logic    dom;
  } tag_t;

  function automatic int memReqMsgNbits(input int o, input int a, input int d);
    return 3 + o + a + $clog2(d / 8) + d;
  endfunction

  function automatic int memRespMsgNbits(input int o, input int d);
    return 3 + o + $clog2(d / 8) + d;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_net_tag_fifo.sv
// Synchronous FIFO holding {source port, domain} for each request in flight.
// Pushes while full and pops while empty are ignored.
module plab5_mcore_mem_net_tag_fifo #(
  parameter int Width = 9,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] pushData_i,
  input  logic             pop_i,
  output logic [Width-1:0] popData_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrNbits = $clog2(Depth);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrNbits-1:0] wrPtr_q, wrPtr_d;
  logic [PtrNbits-1:0] rdPtr_q, rdPtr_d;
  logic [PtrNbits:0]   count_q, count_d;
  logic                pushEn, popEn;

  assign full_o    = (count_q == (PtrNbits + 1)'(Depth));
  assign empty_o   = (count_q == '0);
  assign pushEn    = push_i && !full_o;
  assign popEn     = pop_i && !empty_o;
  assign popData_o = mem_q[rdPtr_q];

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wrPtr_d = pushEn ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = popEn ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d = count_q;
    if (pushEn && !popEn) count_d = count_q + 1'b1;
    if (!pushEn && popEn) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/plab5_mcore_mem_net_rr_sep.sv
// N-port round-robin memory request net with control/data split and in-order response routing.
// Define PLAB5_MCORE_MEMNET_DOMAIN_CHECK_EN to squash and flag responses whose domain mismatches.
module plab5_mcore_mem_net_rr_sep
  import plab5_mcore_mem_net_rr_pkg::*;
#(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_num_ports        = 4,
  parameter int p_max_outstanding  = 4,
  localparam int D   = p_mem_data_nbits,
  localparam int P   = p_num_ports,
  localparam int Rq  = memReqMsgNbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
  localparam int Rqc = Rq - D,
  localparam int Rs  = memRespMsgNbits(p_mem_opaque_nbits, p_mem_data_nbits),
  localparam int Rsc = Rs - D
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [P*Rq-1:0] req_in_msg_i,
  input  logic [P-1:0]   req_in_domain_i,
  input  logic [P-1:0]   req_in_val_i,
  output logic [P-1:0]   req_in_rdy_o,
  output logic [Rqc-1:0] req_out_msg_control_o,
  output logic [D-1:0]   req_out_msg_data_o,
  output logic           req_out_domain_o,
  output logic           req_out_val_o,
  input  logic           req_out_rdy_i,
  input  logic [Rsc-1:0] resp_in_msg_control_i,
  input  logic [D-1:0]   resp_in_msg_data_i,
  input  logic           resp_in_domain_i,
  input  logic           resp_in_val_i,
  output logic           resp_in_rdy_o,
  output logic [P*Rs-1:0] resp_out_msg_o,
  output logic [P-1:0]   resp_out_domain_o,
  output logic [P-1:0]   resp_out_val_o,
  input  logic [P-1:0]   resp_out_rdy_i,
  output logic           domain_err_o
);

  localparam int Ns = $clog2(P);

  logic          reqOutVal_q, reqOutVal_d;
  logic [Ns-1:0] ptr_q, ptr_d;
  logic [Rq-1:0] pipeMsg_q;
  logic          pipeDom_q;

  logic          grantVal, loadOk, load;
  logic [Ns-1:0] grantIdx;
  logic          tagFull, tagEmpty, tagPop;
  tag_t          tagPush, tagHead;
  logic [Ns-1:0] headSrc;
  logic [D-1:0]  respDataOut;
  logic          respDomOut;

  // Scan ports starting at the pointer; the first valid one wins.
  always_comb begin
    logic [Ns-1:0] candIdx;
    grantVal = 1'b0;
    grantIdx = '0;
    candIdx  = '0;
    for (int k = 0; k < P; k++) begin
      candIdx = Ns'((int'(ptr_q) + k) % P);
      if (!grantVal && req_in_val_i[candIdx]) begin
        grantVal = 1'b1;
        grantIdx = candIdx;
      end
    end
  end

  // A full tag FIFO blocks loading even if a response pops this cycle.
  assign loadOk = (!reqOutVal_q || req_out_rdy_i) && !tagFull;
  assign load   = loadOk && grantVal;

  always_comb begin
    req_in_rdy_o = '0;
    if (load) req_in_rdy_o[grantIdx] = 1'b1;
  end

  always_comb begin
    reqOutVal_d = reqOutVal_q;
    ptr_d       = ptr_q;
    if (load) begin
      reqOutVal_d = 1'b1;
      ptr_d       = (grantIdx == Ns'(P - 1)) ? '0 : grantIdx + 1'b1;
    end else if (req_out_rdy_i) begin
      reqOutVal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reqOutVal_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      reqOutVal_q <= reqOutVal_d;
      ptr_q       <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pipeMsg_q <= req_in_msg_i[grantIdx*Rq +: Rq];
      pipeDom_q <= req_in_domain_i[grantIdx];
    end
  end

  assign req_out_val_o         = reqOutVal_q;
  assign req_out_msg_control_o = pipeMsg_q[Rq-1:D];
  assign req_out_msg_data_o    = pipeMsg_q[D-1:0];
  assign req_out_domain_o      = pipeDom_q;

  assign tagPush = '{src: tagSrc_t'(grantIdx), dom: req_in_domain_i[grantIdx]};

  plab5_mcore_mem_net_tag_fifo #(
    .Width ($bits(tag_t)),
    .Depth (p_max_outstanding)
  ) tagFifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (load),
    .pushData_i (tagPush),
    .pop_i      (tagPop),
    .popData_o  (tagHead),
    .full_o     (tagFull),
    .empty_o    (tagEmpty)
  );

  assign headSrc       = tagHead.src[Ns-1:0];
  assign resp_in_rdy_o = !tagEmpty && resp_out_rdy_i[headSrc];
  assign tagPop        = resp_in_val_i && resp_in_rdy_o;

  always_comb begin
    resp_out_val_o = '0;
    if (resp_in_val_i && !tagEmpty) resp_out_val_o[headSrc] = 1'b1;
  end

`ifdef PLAB5_MCORE_MEMNET_DOMAIN_CHECK_EN
  logic domainErr_q;
  logic domMismatch;
  logic [TagSrcNbits-Ns-1:0] unusedTagBits;

  assign unusedTagBits = tagHead.src[TagSrcNbits-1:Ns];
  assign domMismatch   = (resp_in_domain_i != tagHead.dom);
  assign respDataOut   = domMismatch ? '0 : resp_in_msg_data_i;
  assign respDomOut    = tagHead.dom;

  always_ff @(posedge clk) begin
    if (reset) domainErr_q <= 1'b0;
    else if (tagPop && domMismatch) domainErr_q <= 1'b1;
  end

  assign domain_err_o = domainErr_q;
`else
  logic [TagSrcNbits-Ns:0] unusedTagBits;

  assign unusedTagBits = {tagHead.src[TagSrcNbits-1:Ns], tagHead.dom};
  assign respDataOut   = resp_in_msg_data_i;
  assign respDomOut    = resp_in_domain_i;
  assign domain_err_o  = 1'b0;
`endif

  // Every port sees the same payload; only the owning port's valid is raised.
  assign resp_out_msg_o    = {P{resp_in_msg_control_i, respDataOut}};
  assign resp_out_domain_o = {P{respDomOut}};

endmodule

// File: tb/tb_plab5_mcore_mem_net_rr_sep.sv
// Randomized and directed bench for plab5_mcore_mem_net_rr_sep against a queue-based model.
// Honours PLAB5_MCORE_MEMNET_DOMAIN_CHECK_EN for the expected response domain behaviour.
module tb_plab5_mcore_mem_net_rr_sep;
  import plab5_mcore_mem_net_rr_pkg::*;

  localparam int O      = 8;
  localparam int A      = 32;
  localparam int D      = 32;
  localparam int P      = 4;
  localparam int MaxOut = 4;
  localparam int Rq     = memReqMsgNbits(O, A, D);
  localparam int Rqc    = Rq - D;
  localparam int Rs     = memRespMsgNbits(O, D);
  localparam int Rsc    = Rs - D;
  localparam int Words  = (P * Rq + 31) / 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [P*Rq-1:0] req_in_msg = '0;
  logic [P-1:0]    req_in_domain = '0;
  logic [P-1:0]    req_in_val = '0;
  logic [P-1:0]    req_in_rdy;
  logic [Rqc-1:0]  req_out_msg_control;
  logic [D-1:0]    req_out_msg_data;
  logic            req_out_domain;
  logic            req_out_val;
  logic            req_out_rdy = 1'b0;
  logic [Rsc-1:0]  resp_in_msg_control = '0;
  logic [D-1:0]    resp_in_msg_data = '0;
  logic            resp_in_domain = 1'b0;
  logic            resp_in_val = 1'b0;
  logic            resp_in_rdy;
  logic [P*Rs-1:0] resp_out_msg;
  logic [P-1:0]    resp_out_domain;
  logic [P-1:0]    resp_out_val;
  logic [P-1:0]    resp_out_rdy = '0;
  logic            domain_err;

  always #5 clk = ~clk;

  plab5_mcore_mem_net_rr_sep dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_in_msg_i          (req_in_msg),
    .req_in_domain_i       (req_in_domain),
    .req_in_val_i          (req_in_val),
    .req_in_rdy_o          (req_in_rdy),
    .req_out_msg_control_o (req_out_msg_control),
    .req_out_msg_data_o    (req_out_msg_data),
    .req_out_domain_o      (req_out_domain),
    .req_out_val_o         (req_out_val),
    .req_out_rdy_i         (req_out_rdy),
    .resp_in_msg_control_i (resp_in_msg_control),
    .resp_in_msg_data_i    (resp_in_msg_data),
    .resp_in_domain_i      (resp_in_domain),
    .resp_in_val_i         (resp_in_val),
    .resp_in_rdy_o         (resp_in_rdy),
    .resp_out_msg_o        (resp_out_msg),
    .resp_out_domain_o     (resp_out_domain),
    .resp_out_val_o        (resp_out_val),
    .resp_out_rdy_i        (resp_out_rdy),
    .domain_err_o          (domain_err)
  );

  int checkCount = 0;
  int errorCount = 0;

  // Model state: pending output request, rotation pointer, in-flight tags, cache backlog.
  bit          mPipeVal;
  logic [Rq-1:0] mPipeMsg;
  bit          mPipeDom;
  int          mPtr;
  int          tagSrcQ[$];
  bit          tagDomQ[$];
  int          cacheCnt;
  bit          mErr;

  logic [P-1:0] lastReqRdy;
  logic         lastRespInRdy;
  int           lastRespPort;
  logic [D-1:0] lastRespData;
  logic         lastRespDom;
  logic         lastDomErr;
  logic [D-1:0] lastReqOutData;
  logic [P-1:0] grantLog [8];
  logic [D-1:0] stallData;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPipeVal = 1'b0;
    mPtr     = 0;
    tagSrcQ.delete();
    tagDomQ.delete();
    cacheCnt = 0;
    mErr     = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset        = 1'b1;
    req_in_val   = '0;
    req_out_rdy  = 1'b0;
    resp_in_val  = 1'b0;
    resp_out_rdy = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    modelReset();
  endtask

  // One cycle: drive inputs at negedge, compare outputs to the model, then advance the model.
  task automatic applyStimulus(input logic [P-1:0] valMask, input logic [P-1:0] domMask,
                               input logic outRdy, input logic respVal,
                               input logic [D-1:0] respData, input logic respDom,
                               input logic [P-1:0] respRdy);
    logic [Words*32-1:0] msgWords;
    logic [Rsc-1:0]      respCtrl;
    logic [P-1:0]        expRdy, expVal;
    logic [D-1:0]        expData;
    logic                expDom, expInRdy, loadOk, popNow, mismatch;
    int                  g, s, c;
    @(negedge clk);
    for (int w = 0; w < Words; w++) msgWords[w*32 +: 32] = $urandom;
    respCtrl            = Rsc'($urandom);
    req_in_msg          = msgWords[P*Rq-1:0];
    req_in_val          = valMask;
    req_in_domain       = domMask;
    req_out_rdy         = outRdy;
    resp_in_val         = respVal;
    resp_in_msg_control = respCtrl;
    resp_in_msg_data    = respData;
    resp_in_domain      = respDom;
    resp_out_rdy        = respRdy;
    #2;

    loadOk = (!mPipeVal || outRdy) && (tagSrcQ.size() < MaxOut);
    g = -1;
    for (int k = 0; k < P; k++) begin
      c = (mPtr + k) % P;
      if (g < 0 && valMask[c]) g = c;
    end
    expRdy = (loadOk && g >= 0) ? (P'(1) << g) : '0;
    checkOutput("req_in_rdy", req_in_rdy, expRdy);
    checkOutput("req_out_val", req_out_val, mPipeVal);
    if (mPipeVal) begin
      checkOutput("req_out_ctrl", req_out_msg_control, mPipeMsg[Rq-1:D]);
      checkOutput("req_out_data", req_out_msg_data, mPipeMsg[D-1:0]);
      checkOutput("req_out_dom", req_out_domain, mPipeDom);
    end
    lastReqRdy     = req_in_rdy;
    lastReqOutData = req_out_msg_data;

    s = (tagSrcQ.size() > 0) ? tagSrcQ[0] : 0;
    expVal   = (respVal && tagSrcQ.size() > 0) ? (P'(1) << s) : '0;
    expInRdy = (tagSrcQ.size() > 0) ? respRdy[s] : 1'b0;
    checkOutput("resp_out_val", resp_out_val, expVal);
    checkOutput("resp_in_rdy", resp_in_rdy, expInRdy);
    lastRespInRdy = resp_in_rdy;
    lastRespPort  = -1;
    mismatch      = 1'b0;
    if (respVal && tagSrcQ.size() > 0) begin
      mismatch = (respDom != tagDomQ[0]);
`ifdef PLAB5_MCORE_MEMNET_DOMAIN_CHECK_EN
      expDom  = tagDomQ[0];
      expData = mismatch ? '0 : respData;
`else
      expDom  = respDom;
      expData = respData;
`endif
      checkOutput("resp_out_msg", resp_out_msg[s*Rs +: Rs], {respCtrl, expData});
      checkOutput("resp_out_dom", resp_out_domain[s], expDom);
      lastRespPort = s;
      lastRespData = resp_out_msg[s*Rs +: D];
      lastRespDom  = resp_out_domain[s];
    end
    checkOutput("domain_err", domain_err, mErr);
    lastDomErr = domain_err;

    popNow = respVal && tagSrcQ.size() > 0 && respRdy[s];
    if (popNow) begin
`ifdef PLAB5_MCORE_MEMNET_DOMAIN_CHECK_EN
      if (mismatch) mErr = 1'b1;
`endif
      void'(tagSrcQ.pop_front());
      void'(tagDomQ.pop_front());
      if (cacheCnt > 0) cacheCnt--;
    end
    if (mPipeVal && outRdy) cacheCnt++;
    if (loadOk && g >= 0) begin
      mPipeVal = 1'b1;
      mPipeMsg = req_in_msg[g*Rq +: Rq];
      mPipeDom = domMask[g];
      mPtr     = (g + 1) % P;
      tagSrcQ.push_back(g);
      tagDomQ.push_back(domMask[g]);
    end else if (outRdy) begin
      mPipeVal = 1'b0;
    end
  endtask

  initial begin
    logic hd;
    modelReset();
    applyReset();

    // Reset state and response hold-off with an empty tag FIFO.
    applyStimulus('0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("reset_req_out_val", req_out_val, 1'b0);
    applyStimulus('0, '0, 1'b1, 1'b1, 32'hDEAD, 1'b0, 4'hF);
    checkOutput("empty_resp_in_rdy", lastRespInRdy, 1'b0);
    checkOutput("empty_resp_out_val", resp_out_val, 4'h0);

    // Full contention with responses draining: strict rotation 0,1,2,3,0.
    applyReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'hF, 4'h0, 1'b1, cacheCnt > 0, $urandom, 1'b0, 4'hF);
      grantLog[k] = lastReqRdy;
    end
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("rr_grant%0d", k), grantLog[k], 4'b0001 << (k % 4));

    // Four in flight with no responses: the fifth request waits for a pop.
    applyReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
      grantLog[k] = lastReqRdy;
    end
    checkOutput("full_grant3", grantLog[3], 4'b1000);
    checkOutput("full_blocked", grantLog[4], 4'b0000);
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b1, 32'h55, 1'b0, 4'hF);
    checkOutput("full_no_passthru", lastReqRdy, 4'b0000);
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    checkOutput("full_after_pop", lastReqRdy, 4'b0001);

    // Output stall holds the pipe and blocks every port.
    applyReset();
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    applyStimulus(4'hF, 4'h0, 1'b0, 1'b0, '0, 1'b0, 4'hF);
    stallData = lastReqOutData;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'hF, 4'h0, 1'b0, 1'b0, '0, 1'b0, 4'hF);
      checkOutput($sformatf("stall_rdy%0d", k), lastReqRdy, 4'b0000);
      checkOutput($sformatf("stall_data%0d", k), lastReqOutData, stallData);
    end

    // Response routing back to ports 2 then 0, with a port-side stall first.
    applyReset();
    applyStimulus(4'b0100, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    applyStimulus(4'b0001, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    applyStimulus(4'b0000, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    applyStimulus(4'b0000, 4'h0, 1'b1, 1'b1, 32'hAAAA, 1'b0, 4'b1011);
    checkOutput("route_stall_rdy", lastRespInRdy, 1'b0);
    applyStimulus(4'b0000, 4'h0, 1'b1, 1'b1, 32'hAAAA, 1'b0, 4'hF);
    checkOutput("route_port_a", lastRespPort, 2);
    checkOutput("route_data_a", lastRespData, 32'hAAAA);
    applyStimulus(4'b0000, 4'h0, 1'b1, 1'b1, 32'hBBBB, 1'b0, 4'hF);
    checkOutput("route_port_b", lastRespPort, 0);
    checkOutput("route_data_b", lastRespData, 32'hBBBB);

    // Domain mismatch on a response for port 1.
    applyReset();
    applyStimulus(4'b0010, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    applyStimulus(4'b0000, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    applyStimulus(4'b0000, 4'h0, 1'b1, 1'b1, 32'h1234, 1'b1, 4'hF);
    applyStimulus(4'b0000, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
`ifdef PLAB5_MCORE_MEMNET_DOMAIN_CHECK_EN
    checkOutput("dom_data", lastRespData, 32'h0);
    checkOutput("dom_domain", lastRespDom, 1'b0);
    checkOutput("dom_err", lastDomErr, 1'b1);
`else
    checkOutput("dom_data", lastRespData, 32'h1234);
    checkOutput("dom_domain", lastRespDom, 1'b1);
    checkOutput("dom_err", lastDomErr, 1'b0);
`endif

    // Reset with two requests in flight flushes everything and rewinds the pointer.
    applyReset();
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    applyReset();
    applyStimulus(4'h0, 4'h0, 1'b1, 1'b1, 32'h77, 1'b0, 4'hF);
    checkOutput("flush_req_out_val", req_out_val, 1'b0);
    checkOutput("flush_tag_empty", lastRespInRdy, 1'b0);
    applyStimulus(4'hF, 4'h0, 1'b1, 1'b0, '0, 1'b0, 4'hF);
    checkOutput("flush_ptr0", lastReqRdy, 4'b0001);

    // Random traffic against the model.
    applyReset();
    for (int n = 0; n < 400; n++) begin
      hd = (tagDomQ.size() > 0) ? tagDomQ[0] : 1'b0;
      applyStimulus(P'($urandom), P'($urandom), 1'($urandom_range(0, 3) != 0),
                    (cacheCnt > 0) && ($urandom_range(0, 1) == 1), $urandom,
                    ($urandom_range(0, 7) == 0) ? ~hd : hd, P'($urandom | $urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
